lsu_ctrl: RTL and testbench

Load/store control unit for the MEM stage of the RISC-V pipeline. It takes the memory operation latched in the EX/MEM register and runs a request/grant/response handshake with the data memory. It generates byte enables and replicated store data, and aligns and sign- or zero-extends load data. It drives a pipeline stall while an access is outstanding and delivers one result per operation to the MEM/WB path.

---
 rtl/lsu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
`timescale 1ns/1ps
// MEM-stage load/store control: request/grant/response handshake with data memory.
// Store resp 2 cycles after accept, load 3+, misaligned 1; stall holds upstream while busy.
module lsu_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [4:0]        req_rd,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic [4:0]        resp_rd,
   output logic              resp_misalign,
   output logic              stall
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t r_state, w_next;

   logic              r_we;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [1:0]        r_off;
   logic              r_dmem_req;
   logic              r_dmem_we;
   logic [ADDR_W-1:0] r_dmem_addr;
   logic [3:0]        r_dmem_be;
   logic [DATA_W-1:0] r_dmem_wdata;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_data;
   logic [4:0]        r_resp_rd;
   logic              r_resp_misalign;

   logic              w_accept;
   logic              w_misalign;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_load;

   assign w_accept   = (r_state == S_IDLE) && req_valid;
   assign w_misalign = (req_size == 2'b11) ||
                       ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = req_wdata;
      case (req_size)
         2'b00: begin
            w_be    = 4'b0001 << req_addr[1:0];
            w_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << req_addr[1:0];
            w_wdata = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load alignment uses the offset latched at acceptance, not the live request.
   assign w_shift = dmem_rdata >> {r_off, 3'b000};

   always_comb begin
      w_load = w_shift;
      case (r_size)
         2'b00: w_load = {{(DATA_W-8){w_shift[7] & ~r_unsigned}}, w_shift[7:0]};
         2'b01: w_load = {{(DATA_W-16){w_shift[15] & ~r_unsigned}}, w_shift[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      stall     = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            stall     = req_valid;
            if (req_valid) w_next = w_misalign ? S_RESP : S_REQ;
         end
         S_REQ: begin
            stall = 1'b1;
            if (dmem_gnt) w_next = r_we ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            stall = 1'b1;
            if (dmem_rvalid) w_next = S_RESP;
         end
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (rst) begin
         req_ready = 1'b0;
         stall     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we            <= 1'b0;
         r_size          <= 2'b00;
         r_unsigned      <= 1'b0;
         r_off           <= 2'b00;
         r_dmem_req      <= 1'b0;
         r_dmem_we       <= 1'b0;
         r_dmem_addr     <= '0;
         r_dmem_be       <= 4'b0000;
         r_dmem_wdata    <= '0;
         r_resp_valid    <= 1'b0;
         r_resp_data     <= '0;
         r_resp_rd       <= 5'd0;
         r_resp_misalign <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we            <= req_we;
            r_size          <= req_size;
            r_unsigned      <= req_unsigned;
            r_off           <= req_addr[1:0];
            r_dmem_req      <= ~w_misalign;
            r_dmem_we       <= req_we;
            r_dmem_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
            r_dmem_be       <= w_be;
            r_dmem_wdata    <= w_wdata;
            r_resp_data     <= '0;
            r_resp_rd       <= req_rd;
            r_resp_misalign <= w_misalign;
         end else if ((r_state == S_REQ) && dmem_gnt) begin
            r_dmem_req <= 1'b0;
         end
         if ((r_state == S_WAIT) && dmem_rvalid) r_resp_data <= w_load;
         r_resp_valid <= (w_next == S_RESP);
      end
   end

   assign dmem_req      = r_dmem_req;
   assign dmem_we       = r_dmem_we;
   assign dmem_addr     = r_dmem_addr;
   assign dmem_be       = r_dmem_be;
   assign dmem_wdata    = r_dmem_wdata;
   assign resp_valid    = r_resp_valid;
   assign resp_data     = r_resp_data;
   assign resp_rd       = r_resp_rd;
   assign resp_misalign = r_resp_misalign;

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
// Bench for lsu_ctrl: directed and random ops, scoreboard of responses, reactive memory model.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        resp_valid, resp_misalign, stall;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;

   always #5 clk = ~clk;

   lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_misalign(resp_misalign), .stall(stall)
   );

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        mis;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   // What the memory model expects to see for the op in flight.
   logic        exp_access, exp_we;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [3:0]  exp_be;
   int          exp_gd, exp_rv;
   bit          manual = 1'b0;
   int          m_gcnt = 0;
   int          m_rvleft = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: access width in bytes, alignment, lane mapping.
   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'd3) return 1'b1;
      return (addr % nbytes(size)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] be = 4'b0000;
      int off = int'(addr % 4);
      for (int i = 0; i < nbytes(size); i++) be[off + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] r;
      int n = nbytes(size);
      for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = wd[8*(lane % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                              input logic [31:0] addr, input logic [31:0] rdata);
      int n = nbytes(size);
      logic [31:0] v, mask;
      if (n == 4) return rdata;
      v    = rdata >> (8 * (addr % 4));
      mask = (32'd1 << (8 * n)) - 32'd1;
      v    = v & mask;
      if (!uns && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, {dmem_req, dmem_we, dmem_be, resp_valid, resp_misalign, resp_rd,
                            req_ready, stall}, 64'h0);
      check({tag, "_addr"}, dmem_addr, 64'h0);
      check({tag, "_wdata"}, dmem_wdata, 64'h0);
      check({tag, "_rdata"}, resp_data, 64'h0);
   endtask

   task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int gd, input int rv);
      bit   mis = model_mis(size, addr);
      int   lat = mis ? 1 : (we ? 2 + gd : 2 + gd + rv);
      int   c;
      exp_t e;
      exp_access = ~mis;
      exp_we     = we;
      exp_addr   = {addr[31:2], 2'b00};
      exp_be     = model_be(size, addr);
      exp_wdata  = model_wdata(size, wdata);
      exp_rdata  = rdata;
      exp_gd     = gd;
      exp_rv     = rv;
      @(posedge clk);
      #1;
      req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
      @(negedge clk);
      c = cyc;
      check("ready_idle", req_ready, 1);
      check("stall_accept", stall, 1);
      e.data = (mis || we) ? 32'h0 : model_load(size, uns, addr, rdata);
      e.rd   = rd;
      e.mis  = mis;
      e.cyc  = c + lat;
      sb.push_back(e);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         check("busy_ready", req_ready, 0);
         check(k < lat ? "busy_stall" : "resp_stall", stall, (k < lat) ? 1 : 0);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1 req_valid = 1'b0;
      end
   endtask

   // Memory model: grants after exp_gd cycles, returns rdata exp_rv cycles after grant,
   // and throws in stray rvalid pulses whenever the DUT must ignore them.
   initial begin
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (!manual) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            if (rst) begin
               m_gcnt = 0; m_rvleft = 0;
            end else if (m_rvleft > 0) begin
               m_rvleft--;
               if (m_rvleft == 0) begin
                  dmem_rvalid = 1'b1;
                  dmem_rdata  = exp_rdata;
               end
            end else begin
               if (dmem_req) begin
                  check("dmem_req_legal", dmem_req, exp_access);
                  check("dmem_addr_be_we", {dmem_addr, dmem_be, dmem_we}, {exp_addr, exp_be, exp_we});
                  if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
                  if (m_gcnt >= exp_gd) begin
                     dmem_gnt = 1'b1;
                     m_gcnt   = 0;
                     if (!exp_we) m_rvleft = exp_rv;
                  end else begin
                     m_gcnt++;
                  end
               end
               if ($urandom_range(0, 3) == 0) dmem_rvalid = 1'b1;
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, required 0", cyc);
            end else begin
               e = sb.pop_front();
               check("resp_data", resp_data, e.data);
               check("resp_rd", resp_rd, e.rd);
               check("resp_misalign", resp_misalign, e.mis);
               check("resp_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

   logic        r_we, r_uns;
   logic [1:0]  r_size;
   logic [31:0] r_addr;

   initial begin
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
      exp_access = 1'b0; exp_we = 1'b0; exp_addr = 0; exp_wdata = 0; exp_rdata = 0;
      exp_be = 0; exp_gd = 0; exp_rv = 1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0; req_valid = 1'b0;

      do_op(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd5, 32'h0, 0, 1);
      idle(1);
      do_op(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 5'd6, 32'h0, 3, 1);
      do_op(1'b0, 2'd0, 1'b0, 32'h202, 32'h0, 5'd7, 32'h12F03456, 0, 2);
      do_op(1'b0, 2'd0, 1'b1, 32'h202, 32'h0, 5'd8, 32'h12F03456, 1, 2);
      do_op(1'b0, 2'd1, 1'b0, 32'h301, 32'h0, 5'd9, 32'h0, 0, 1);
      do_op(1'b0, 2'd2, 1'b0, 32'h302, 32'h0, 5'd10, 32'h0, 0, 1);
      idle(2);

      // Reset while a load waits for data; the late rvalid must be dropped.
      manual = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      @(posedge clk);
      #1 req_we = 1'b0; req_size = 2'd2; req_addr = 32'h400; req_rd = 5'd11; req_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_test_req", dmem_req, 1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      check("rst_test_wait_stall", stall, 1);
      rst = 1'b1;
      #1 check_reset_outputs("rst_mid_op");
      @(negedge clk);
      req_valid = 1'b0;
      check_reset_outputs("rst_held");
      rst = 1'b0;
      dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE0000;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("rst_no_resp", {resp_valid, dmem_req}, 0);
      end
      manual = 1'b0; m_gcnt = 0; m_rvleft = 0;
      do_op(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 5'd12, 32'h89ABCDEF, 0, 1);

      repeat (80) begin
         r_we   = 1'($urandom_range(0, 1));
         r_uns  = 1'($urandom_range(0, 1));
         r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r_addr = $urandom;
         if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
         do_op(r_we, r_size, r_uns, r_addr, $urandom, 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 3), $urandom_range(1, 3));
         idle($urandom_range(0, 2));
      end

      idle(5);
      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
